// File: rtl/cpu_pkg.sv
// Shared core definitions: register-file geometry and the RF dump engine state encoding.
package cpu_pkg;

    localparam int RF_AW         = 5;
    localparam int RF_DW         = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/rf_dump.sv
// Debug read-out engine: walks the register file through a dedicated read port,
// streams each value with its index and accumulates a wrapping additive checksum.
module rf_dump
    import cpu_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          busy,
    output logic          cpu_stall,
    output logic          done,
    output logic [DW-1:0] checksum
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t   state;
    dump_state_t   state_next;
    logic [AW-1:0] idx;
    logic          accept;

    // abort takes priority over a simultaneous handshake, so the word is not counted
    assign accept = (state == SEND) && out_ready && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        rd_addr    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                rd_addr    = idx;
                state_next = abort ? IDLE : SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    state_next = out_last ? DONE : READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_stall = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        checksum <= '0;
                    end
                end
                READ: begin
                    if (!abort) begin
                        out_data  <= rd_data;
                        out_index <= idx;
                        out_last  <= (idx == LAST_IDX);
                    end
                end
                SEND: begin
                    if (accept) begin
                        checksum <= checksum + out_data;
                        if (!out_last) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
